// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB configuration sequencer.
package sccb_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_LOAD,
        S_REQ,
        S_GAP,
        S_DONE,
        S_ERR
    } cfg_state_e;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h42;

    // LUT word layout: {reg, data}
    localparam int unsigned LUT_REG_MSB  = 15;
    localparam int unsigned LUT_REG_LSB  = 8;
    localparam int unsigned LUT_DATA_MSB = 7;
    localparam int unsigned LUT_DATA_LSB = 0;

    localparam int unsigned IDX_W   = 8;
    localparam int unsigned TMR_W   = 20;
    localparam int unsigned RETRY_W = 8;

endpackage

// File: rtl/sccb_cfg_sequencer_if.sv
// Request/ack handshake between the configuration sequencer and an SCCB master.
interface sccb_cfg_sequencer_if;
    logic       sccb_req;
    logic       sccb_rd;
    logic [7:0] sccb_dev;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_wdata;
    logic       sccb_ack;
    logic       sccb_nack;
    logic [7:0] sccb_rdata;

    modport master (
        output sccb_req, sccb_rd, sccb_dev, sccb_reg, sccb_wdata,
        input  sccb_ack, sccb_nack, sccb_rdata
    );

    modport slave (
        input  sccb_req, sccb_rd, sccb_dev, sccb_reg, sccb_wdata,
        output sccb_ack, sccb_nack, sccb_rdata
    );
endinterface

// File: rtl/sccb_cfg_timer.sv
// Loadable down-counter with a zero flag; shared by the power-up and gap waits.
module sccb_cfg_timer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks a register LUT after power-up, issuing SCCB ID reads then writes with NACK retry.
// Optional ID read/compare phase enabled by defining CFG_ID_CHECK_EN.
module sccb_cfg_sequencer
    import sccb_cfg_pkg::*;
#(
    parameter int unsigned LUT_SIZE   = 167,
    parameter int unsigned ID_ENTRIES = 2,
    parameter logic [7:0]  DEV_ADDR   = DEV_ADDR_DEFAULT,
    parameter logic [19:0] PWR_DELAY  = 20'd1_000_000,
    parameter logic [15:0] GAP_CYCLES = 16'd500,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    output logic [IDX_W-1:0]     lut_index,
    input  logic [15:0]          lut_data,
    sccb_cfg_sequencer_if.master sccb,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 id_ok
);

    // Timer is loaded with N-1 so each wait state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] PWR_LOAD = (PWR_DELAY == '0) ? '0 : PWR_DELAY - 20'd1;
    localparam logic [TMR_W-1:0] GAP_LOAD = (GAP_CYCLES == '0) ? '0 : 20'(GAP_CYCLES) - 20'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);
`ifdef CFG_ID_CHECK_EN
    localparam logic [IDX_W-1:0] START_IDX = '0;
`else
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(ID_ENTRIES);
`endif

    cfg_state_e           state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 adv_q, adv_d;
    logic                 req_q, req_d;
    logic                 rd_q, rd_d;
    logic [7:0]           dev_q, dev_d;
    logic [7:0]           reg_q, reg_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 id_ok_q, id_ok_d;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_zero_c;
    logic                 entry_is_id_c;

    assign entry_is_id_c = (index_q < IDX_W'(ID_ENTRIES));

    sccb_cfg_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    // Next-state, counters and registered outputs
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        retry_d  = retry_q;
        adv_d    = adv_q;
        rd_d     = rd_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wdata_d  = wdata_q;
        id_ok_d  = id_ok_q;
        tmr_load = 1'b0;
        tmr_val  = PWR_LOAD;

        case (state_q)
            S_IDLE: begin
                state_d  = S_PWR_WAIT;
                index_d  = START_IDX;
                tmr_load = 1'b1;
            end
            S_PWR_WAIT: begin
                if (tmr_zero_c) state_d = S_LOAD;
            end
            S_LOAD: begin
                reg_d   = lut_data[LUT_REG_MSB:LUT_REG_LSB];
                wdata_d = lut_data[LUT_DATA_MSB:LUT_DATA_LSB];
                rd_d    = entry_is_id_c;
                dev_d   = entry_is_id_c ? (DEV_ADDR | 8'h01) : DEV_ADDR;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (sccb.sccb_ack) begin
                    tmr_val = GAP_LOAD;
                    if (sccb.sccb_nack) begin
                        retry_d = retry_q + RETRY_W'(1);
                        adv_d   = 1'b0;
                        if (retry_q >= RETRY_W'(RETRY_MAX)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d  = S_GAP;
                            tmr_load = 1'b1;
                        end
                    end else begin
                        // On reads the write-data register holds the expected ID byte
                        if (rd_q && (sccb.sccb_rdata != wdata_q)) id_ok_d = 1'b0;
                        adv_d    = 1'b1;
                        state_d  = S_GAP;
                        tmr_load = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tmr_zero_c) begin
                    if (adv_q) begin
                        retry_d = '0;
                        adv_d   = 1'b0;
                        if (index_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + IDX_W'(1);
                            state_d = S_LOAD;
                        end
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (cfg_start) begin
                    state_d  = S_PWR_WAIT;
                    index_d  = START_IDX;
                    retry_d  = '0;
                    adv_d    = 1'b0;
                    id_ok_d  = 1'b1;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifndef CFG_ID_CHECK_EN
        rd_d    = 1'b0;
        id_ok_d = 1'b1;
`endif

        req_d  = (state_d == S_REQ);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        busy_d = !(done_d || err_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            index_q <= '0;
            retry_q <= '0;
            adv_q   <= 1'b0;
            req_q   <= 1'b0;
            rd_q    <= 1'b0;
            dev_q   <= DEV_ADDR;
            reg_q   <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            id_ok_q <= 1'b1;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            retry_q <= retry_d;
            adv_q   <= adv_d;
            req_q   <= req_d;
            rd_q    <= rd_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            id_ok_q <= id_ok_d;
        end
    end

    assign lut_index       = index_q;
    assign sccb.sccb_req   = req_q;
    assign sccb.sccb_rd    = rd_q;
    assign sccb.sccb_dev   = dev_q;
    assign sccb.sccb_reg   = reg_q;
    assign sccb.sccb_wdata = wdata_q;
    assign cfg_busy        = busy_q;
    assign cfg_done        = done_q;
    assign cfg_err         = err_q;
    assign id_ok           = id_ok_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer with a small SCCB responder that acks 3 cycles after req.
module tb_sccb_cfg_sequencer;

`ifdef CFG_ID_CHECK_EN
    localparam int START = 0;
`else
    localparam int START = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        cfg_busy, cfg_done, cfg_err, id_ok;

    int total = 0;
    int bad   = 0;

    sccb_cfg_sequencer_if sccb ();

    sccb_cfg_sequencer #(
        .LUT_SIZE   (5),
        .ID_ENTRIES (2),
        .DEV_ADDR   (8'h42),
        .PWR_DELAY  (20'd10),
        .GAP_CYCLES (16'd4),
        .RETRY_MAX  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .sccb      (sccb),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .id_ok     (id_ok)
    );

    always #5 clk = ~clk;

    logic [15:0] lut_mem [0:7];
    assign lut_data = (lut_index < 8'd5) ? lut_mem[lut_index[2:0]] : 16'h0000;

    // SCCB responder and transaction log
    logic [7:0]  rd_resp [0:1];
    int          cyc = 0, cnt = 0, log_n = 0, stab_bad = 0, cap_start = 0;
    int          nack_entry = 0, nack_left = 0;
    logic        stray = 1'b0;
    logic [24:0] cap, txn;
    logic [24:0] log_txn [0:31];
    int          log_idx [0:31];
    logic        log_nack [0:31];
    int          log_start [0:31];

    always @(negedge clk) begin
        cyc++;
        sccb.sccb_ack  = 1'b0;
        sccb.sccb_nack = 1'b0;
        if (stray) begin
            sccb.sccb_ack  = 1'b1;
            sccb.sccb_nack = 1'b1;
            stray = 1'b0;
        end
        if (!sccb.sccb_req) begin
            cnt = 0;
        end else begin
            txn = {sccb.sccb_rd, sccb.sccb_dev, sccb.sccb_reg, sccb.sccb_wdata};
            if (cnt == 0) begin
                cap = txn;
                cap_start = cyc;
            end else if (txn !== cap) begin
                stab_bad++;
            end
            cnt++;
            if (cnt == 3) begin
                sccb.sccb_ack  = 1'b1;
                sccb.sccb_nack = (nack_left > 0) && (int'(lut_index) == nack_entry);
                if (sccb.sccb_nack) nack_left--;
                sccb.sccb_rdata = (lut_index < 8'd2) ? rd_resp[lut_index[0]] : 8'h00;
                if (log_n < 32) begin
                    log_txn[log_n]   = cap;
                    log_idx[log_n]   = int'(lut_index);
                    log_nack[log_n]  = sccb.sccb_nack;
                    log_start[log_n] = cap_start;
                end
                log_n++;
            end
        end
    end

    function automatic logic [24:0] exp_txn(input int idx);
        logic rd;
        rd = (START == 0) && (idx < 2);
        return {rd, (rd ? 8'h43 : 8'h42), lut_mem[3'(idx)]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cfg_start = 1'b0;
        repeat (2) @(negedge clk);
        log_n = 0;
        stab_bad = 0;
        nack_left = 0;
        rd_resp[0] = 8'h76;
        rd_resp[1] = 8'h73;
        rst = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (sccb.sccb_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", sccb.sccb_req); end
        total++; if (sccb.sccb_rd !== 1'b0) begin bad++; $display("FAIL rst_rd got=%0h exp=0", sccb.sccb_rd); end
        total++; if (sccb.sccb_dev !== 8'h42) begin bad++; $display("FAIL rst_dev got=%0h exp=42", sccb.sccb_dev); end
        total++; if (sccb.sccb_reg !== 8'h00) begin bad++; $display("FAIL rst_reg got=%0h exp=0", sccb.sccb_reg); end
        total++; if (sccb.sccb_wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%0h exp=0", sccb.sccb_wdata); end
        total++; if (lut_index !== 8'h00) begin bad++; $display("FAIL rst_index got=%0h exp=0", lut_index); end
        total++; if ({cfg_busy, cfg_done, cfg_err, id_ok} !== 4'b1001) begin bad++; $display("FAIL rst_status got=%b exp=1001", {cfg_busy, cfg_done, cfg_err, id_ok}); end
    endtask

    task automatic test_basic_walk();
        int n;
        bit ok;
        do_reset();
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (n == 3) stray = 1'b1;
            if (sccb.sccb_req) break;
        end
        total++; if (n !== 12) begin bad++; $display("FAIL first_req_latency got=%0d exp=12", n); end
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_end(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=%0d exp=1", ok); end
        total++; if ({cfg_busy, cfg_done, cfg_err, id_ok} !== 4'b0101) begin bad++; $display("FAIL basic_status got=%b exp=0101", {cfg_busy, cfg_done, cfg_err, id_ok}); end
        total++; if (sccb.sccb_req !== 1'b0) begin bad++; $display("FAIL basic_req_idle got=%0h exp=0", sccb.sccb_req); end
        total++; if (lut_index !== 8'd4) begin bad++; $display("FAIL basic_last_index got=%0d exp=4", lut_index); end
        total++; if (log_n !== 5 - START) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", log_n, 5 - START); end
        for (int k = 0; k < log_n && k < 5 - START; k++) begin
            total++; if (log_idx[k] !== START + k || log_txn[k] !== exp_txn(START + k) || log_nack[k] !== 1'b0) begin
                bad++; $display("FAIL basic_txn%0d got=idx%0d/%h exp=idx%0d/%h", k, log_idx[k], log_txn[k], START + k, exp_txn(START + k));
            end
        end
        total++; if (log_start[1] - log_start[0] !== 8) begin bad++; $display("FAIL basic_gap got=%0d exp=8", log_start[1] - log_start[0]); end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL basic_stable got=%0d exp=0", stab_bad); end
    endtask

    task automatic test_id_mismatch();
        bit ok;
        do_reset();
        rd_resp[1] = 8'h74;
        wait_end(500, ok);
        total++; if (!ok || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin bad++; $display("FAIL mism_done got=%0d%0d%0d exp=110", ok, cfg_done, cfg_err); end
        total++; if (id_ok !== ((START == 0) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL mism_id_ok got=%0h exp=%0h", id_ok, (START == 0) ? 1'b0 : 1'b1); end
        total++; if (log_n !== 5 - START) begin bad++; $display("FAIL mism_count got=%0d exp=%0d", log_n, 5 - START); end
    endtask

    task automatic test_nack_retry();
        bit ok;
        int q[$];
        bit qn[$];
        do_reset();
        nack_entry = 3;
        nack_left = 2;
        for (int i = START; i < 5; i++) begin
            if (i == 3) begin
                q.push_back(3); qn.push_back(1'b1);
                q.push_back(3); qn.push_back(1'b1);
            end
            q.push_back(i); qn.push_back(1'b0);
        end
        wait_end(800, ok);
        total++; if (!ok || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin bad++; $display("FAIL nack_done got=%0d%0d%0d exp=110", ok, cfg_done, cfg_err); end
        total++; if (log_n !== q.size()) begin bad++; $display("FAIL nack_count got=%0d exp=%0d", log_n, q.size()); end
        for (int k = 0; k < log_n && k < q.size(); k++) begin
            total++; if (log_idx[k] !== q[k] || log_txn[k] !== exp_txn(q[k]) || log_nack[k] !== qn[k]) begin
                bad++; $display("FAIL nack_txn%0d got=idx%0d/%h/%0d exp=idx%0d/%h/%0d", k, log_idx[k], log_txn[k], log_nack[k], q[k], exp_txn(q[k]), qn[k]);
            end
        end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL nack_stable got=%0d exp=0", stab_bad); end
    endtask

    task automatic test_err_restart();
        bit ok;
        int n;
        int exp_n;
        do_reset();
        nack_entry = 2;
        nack_left = 4;
        exp_n = 6 - START;
        wait_end(800, ok);
        total++; if (!ok || {cfg_busy, cfg_done, cfg_err} !== 3'b001) begin bad++; $display("FAIL err_status got=%0d/%b exp=1/001", ok, {cfg_busy, cfg_done, cfg_err}); end
        total++; if (sccb.sccb_req !== 1'b0) begin bad++; $display("FAIL err_req got=%0h exp=0", sccb.sccb_req); end
        total++; if (lut_index !== 8'd2) begin bad++; $display("FAIL err_index got=%0d exp=2", lut_index); end
        total++; if (log_n !== exp_n) begin bad++; $display("FAIL err_count got=%0d exp=%0d", log_n, exp_n); end
        total++; if (log_n >= 4 && (log_idx[log_n-1] !== 2 || log_nack[log_n-1] !== 1'b1 || log_idx[log_n-4] !== 2 || log_nack[log_n-4] !== 1'b1)) begin
            bad++; $display("FAIL err_entries got=idx%0d/%0d exp=idx2/1", log_idx[log_n-1], log_nack[log_n-1]);
        end
        repeat (3) @(negedge clk);
        total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_hold got=%0h exp=1", cfg_err); end
        log_n = 0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        total++; if ({cfg_busy, cfg_err} !== 2'b10) begin bad++; $display("FAIL restart_status got=%b exp=10", {cfg_busy, cfg_err}); end
        n = 1;
        for (int i = 0; i < 50 && !sccb.sccb_req; i++) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== 12) begin bad++; $display("FAIL restart_latency got=%0d exp=12", n); end
        total++; if (lut_index !== 8'(START)) begin bad++; $display("FAIL restart_index got=%0d exp=%0d", lut_index, START); end
        wait_end(500, ok);
        total++; if (!ok || cfg_done !== 1'b1 || log_n !== 5 - START || log_idx[0] !== START) begin
            bad++; $display("FAIL restart_walk got=%0d/%0d/%0d exp=1/%0d/%0d", cfg_done, log_n, log_idx[0], 5 - START, START);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int n;
        do_reset();
        for (int i = 0; i < 50 && !sccb.sccb_req; i++) @(negedge clk);
        total++; if (sccb.sccb_req !== 1'b1) begin bad++; $display("FAIL rstmid_req_seen got=%0h exp=1", sccb.sccb_req); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (sccb.sccb_req !== 1'b0) begin bad++; $display("FAIL rstmid_req_drop got=%0h exp=0", sccb.sccb_req); end
        total++; if (lut_index !== 8'd0 || cfg_busy !== 1'b1) begin bad++; $display("FAIL rstmid_state got=%0d/%0h exp=0/1", lut_index, cfg_busy); end
        rst = 1'b0;
        log_n = 0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (sccb.sccb_req) break;
        end
        total++; if (n !== 12) begin bad++; $display("FAIL rstmid_latency got=%0d exp=12", n); end
        total++; if (lut_index !== 8'(START)) begin bad++; $display("FAIL rstmid_index got=%0d exp=%0d", lut_index, START); end
        wait_end(500, ok);
        total++; if (!ok || cfg_done !== 1'b1 || log_n !== 5 - START || log_idx[0] !== START) begin
            bad++; $display("FAIL rstmid_walk got=%0d/%0d/%0d exp=1/%0d/%0d", cfg_done, log_n, log_idx[0], 5 - START, START);
        end
    endtask

    initial begin
        lut_mem[0] = 16'h0A76;
        lut_mem[1] = 16'h0B73;
        lut_mem[2] = 16'h3A04;
        lut_mem[3] = 16'h40D0;
        lut_mem[4] = 16'h1204;
        lut_mem[5] = 16'h0000;
        lut_mem[6] = 16'h0000;
        lut_mem[7] = 16'h0000;
        rd_resp[0] = 8'h76;
        rd_resp[1] = 8'h73;
        sccb.sccb_ack   = 1'b0;
        sccb.sccb_nack  = 1'b0;
        sccb.sccb_rdata = 8'h00;

        test_reset();
        test_basic_walk();
        test_id_mismatch();
        test_nack_retry();
        test_err_restart();
        test_rst_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sccb_cfg_sequencer.md
SCCB_CFG_SEQUENCER -- requirements
Module: sccb_cfg_sequencer

Interface
REQ-001 Parameter LUT_SIZE, default 167: number of LUT entries walked, index 0..LUT_SIZE-1.
REQ-002 Parameter ID_ENTRIES, default 2: entries 0..ID_ENTRIES-1 are ID reads {reg, expected}; the rest are writes {reg, data}.
REQ-003 Parameter DEV_ADDR, default 8'h42: SCCB 8-bit write address; read address is DEV_ADDR|1.
REQ-004 Parameter PWR_DELAY, default 20'd1_000_000: idle cycles after reset or restart before the first transaction.
REQ-005 Parameter GAP_CYCLES, default 16'd500: idle cycles between completed transactions.
REQ-006 Parameter RETRY_MAX, default 3: NACK retries per entry.
REQ-007 clk  in  1  single clock; reset is synchronous and active-high.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 cfg_start  in  1  restart pulse; honoured only in DONE or ERR.
REQ-010 lut_index  out  8  LUT address.
REQ-011 lut_data  in  16  combinational LUT word, {reg[15:8], data[7:0]}.
REQ-012 sccb_req  out  1  transaction request, level.
REQ-013 sccb_rd  out  1  1 = read, 0 = write.
REQ-014 sccb_dev  out  8  device address.
REQ-015 sccb_reg  out  8  register address.
REQ-016 sccb_wdata  out  8  write data.
REQ-017 sccb_ack  in  1  one-cycle completion pulse from the SCCB master.
REQ-018 sccb_nack  in  1  valid with sccb_ack; 1 = slave NACK.
REQ-019 sccb_rdata  in  8  read byte, valid with sccb_ack.
REQ-020 cfg_busy / cfg_done / cfg_err / id_ok  out  1 each  status.

Function
REQ-021 States: IDLE, PWR_WAIT, LOAD, REQ, GAP, DONE, ERR.
REQ-022 IDLE -> PWR_WAIT unconditionally one cycle after reset release; PWR_WAIT counts PWR_DELAY cycles, then -> LOAD.
REQ-023 LOAD drives lut_index and registers lut_data into sccb_reg/sccb_wdata in the same cycle; next cycle -> REQ.
REQ-024 REQ asserts sccb_req; sccb_rd, sccb_dev, sccb_reg and sccb_wdata stay constant until sccb_ack; sccb_req drops in the cycle after sccb_ack.
REQ-025 ack without nack: on a read, compare sccb_rdata to the expected byte and clear id_ok on mismatch; then -> GAP.
REQ-026 ack with nack: increment the retry counter; while retries <= RETRY_MAX -> GAP, then re-issue the same entry; on exceeding RETRY_MAX -> ERR.
REQ-027 GAP counts GAP_CYCLES, then advances: index+1 -> LOAD, or -> DONE after index LUT_SIZE-1; the retry counter clears on every advance.
REQ-028 DONE and ERR hold until cfg_start, which clears index, status and retries and enters PWR_WAIT.
REQ-029 cfg_start in any other state is ignored.
REQ-030 cfg_busy = 1 in all states except DONE and ERR.
REQ-031 cfg_done = 1 only in DONE; cfg_err = 1 only in ERR.
REQ-032 id_ok is set on start and cleared on the first ID mismatch; it is sticky until restart.
REQ-033 A sccb_ack arriving in any state other than REQ is ignored.
REQ-034 The index counter never wraps; the last-entry check uses LUT_SIZE-1.

Reset
REQ-035 Reset values: state IDLE, lut_index 0, sccb_req 0, sccb_rd 0, sccb_dev 8'h42, sccb_reg 0, sccb_wdata 0, cfg_busy 1, cfg_done 0, cfg_err 0, id_ok 1, all counters 0.
REQ-036 Reset mid-transaction drops sccb_req in the next cycle and abandons the transaction.

Configuration
REQ-037 With CFG_ID_CHECK_EN defined, entries below ID_ENTRIES are issued as reads and a mismatch clears id_ok.
REQ-038 With CFG_ID_CHECK_EN not defined, those entries are skipped (walk starts at ID_ENTRIES), sccb_rd is constant 0, and id_ok is tied 1.

Structure
REQ-039 Package sccb_cfg_pkg holds the state enumeration, DEV_ADDR default, and LUT word field positions (reg [15:8], data [7:0]).
REQ-040 Sub-module sccb_cfg_timer is a loadable down-counter with a zero flag, shared by PWR_WAIT and GAP.

Verification
REQ-041 Bench parameters PWR_DELAY=10, GAP_CYCLES=4, LUT_SIZE=5, ID_ENTRIES=2; SCCB model acks 3 cycles after req; LUT {0A76,0B73,3A04,40D0,1204}, reads return 76/73 -> two reads then three writes in order, cfg_done=1, id_ok=1.
REQ-042 Same, entry 1 read returns 8'h74 -> walk completes, cfg_done=1, id_ok=0.
REQ-043 NACK on entry 3 twice, then ack -> entry 3 issued 3 times with identical reg 8'h40 / wdata 8'hD0, then completion.
REQ-044 NACK on entry 2 four times with RETRY_MAX=3 -> cfg_err=1, sccb_req=0, lut_index=2; cfg_start -> PWR_WAIT then restart from entry 0.
REQ-045 rst asserted while sccb_req=1 -> sccb_req=0 next cycle; walk restarts at entry 0 after 10 idle cycles.
REQ-046 Build without CFG_ID_CHECK_EN -> first request is write reg 8'h3A data 8'h04; sccb_rd never 1.
